j1_mem_arbiter: RTL and testbench



---
 rtl/j1_pkg.sv | 24 ++
 rtl/j1_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_j1_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_pkg.sv
// Shared definitions for the J1 memory subsystem: arbiter state encoding,
// port indices and a saturating-increment helper for 16-bit statistics counters.
package j1_pkg;

  typedef enum logic [1:0] {
    ARB_RUN     = 2'd0,
    ARB_LOCKED  = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic CORE_P = 1'b0;
  localparam logic HOST_P = 1'b1;

  localparam logic [15:0] CNT16_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == CNT16_MAX) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/j1_mem_arbiter.sv
// Shares one single-port synchronous RAM between the J1 core and a host/loader
// port: round-robin under contention, host lock sequencing with core hold.
module j1_mem_arbiter
  import j1_pkg::*;
#(
  parameter int   ADDR_W    = 16,
  parameter int   DATA_W    = 16,
  parameter logic BOOT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              h_lock,
  output logic              core_hold,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              cnt_clr,
  output logic [15:0]       cnt_denied
);

  localparam arb_state_e RESET_STATE = BOOT_HOLD ? ARB_LOCKED : ARB_RUN;

  arb_state_e        state_r;
  logic              last_r;
  logic              h_lock_q_r;
  logic              core_hold_r;
  logic              c_rvalid_r;
  logic              h_rvalid_r;
  logic [15:0]       cnt_r;

  logic              c_gnt_s;
  logic              h_gnt_s;
  logic              m_we_s;
  logic [ADDR_W-1:0] m_addr_s;
  logic [DATA_W-1:0] m_wdata_s;
  logic              denied_s;

  // Grant decision; grants are suppressed while reset is asserted so no RAM access leaks out.
  always_comb begin
    c_gnt_s = 1'b0;
    h_gnt_s = 1'b0;
    if (reset_n) begin
      case (state_r)
        ARB_RUN: begin
          if (h_lock) begin
            h_gnt_s = h_req;
          end else if (c_req && h_req) begin
            if (last_r == HOST_P) begin
              c_gnt_s = 1'b1;
            end else begin
              h_gnt_s = 1'b1;
            end
          end else begin
            c_gnt_s = c_req;
            h_gnt_s = h_req;
          end
        end
        ARB_LOCKED: begin
          h_gnt_s = h_req;
        end
        ARB_RELEASE: begin
          c_gnt_s = 1'b0;
          h_gnt_s = 1'b0;
        end
        default: begin
          c_gnt_s = 1'b0;
          h_gnt_s = 1'b0;
        end
      endcase
    end else begin
      c_gnt_s = 1'b0;
      h_gnt_s = 1'b0;
    end
  end

  // RAM command mux; an idle bus is driven to all zeros.
  always_comb begin
    m_we_s    = 1'b0;
    m_addr_s  = '0;
    m_wdata_s = '0;
    if (c_gnt_s) begin
      m_we_s    = c_we;
      m_addr_s  = c_addr;
      m_wdata_s = c_wdata;
    end else if (h_gnt_s) begin
      m_we_s    = h_we;
      m_addr_s  = h_addr;
      m_wdata_s = h_wdata;
    end else begin
      m_we_s    = 1'b0;
      m_addr_s  = '0;
      m_wdata_s = '0;
    end
  end

  // Lock FSM with round-robin pointer and registered core hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= RESET_STATE;
      last_r      <= HOST_P;
      h_lock_q_r  <= 1'b0;
      core_hold_r <= BOOT_HOLD;
    end else begin
      h_lock_q_r  <= h_lock;
      core_hold_r <= (state_r != ARB_RUN);
      case (state_r)
        ARB_RUN: begin
          if (h_lock) begin
            state_r <= ARB_LOCKED;
          end else begin
            state_r <= ARB_RUN;
          end
        end
        ARB_LOCKED: begin
          if (h_lock_q_r && !h_lock) begin
            state_r <= ARB_RELEASE;
          end else begin
            state_r <= ARB_LOCKED;
          end
        end
        ARB_RELEASE: begin
          state_r <= ARB_RUN;
        end
        default: begin
          state_r <= RESET_STATE;
        end
      endcase
      // Leaving a lock hands the next contention to the core.
      if (state_r == ARB_RELEASE) begin
        last_r <= HOST_P;
      end else if (c_gnt_s) begin
        last_r <= CORE_P;
      end else if (h_gnt_s) begin
        last_r <= HOST_P;
      end else begin
        last_r <= last_r;
      end
    end
  end

  assign denied_s = (c_req & ~c_gnt_s) | (h_req & ~h_gnt_s);

  // Read-valid tracking and the saturating denied-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_rvalid_r <= 1'b0;
      h_rvalid_r <= 1'b0;
      cnt_r      <= 16'd0;
    end else begin
      c_rvalid_r <= c_gnt_s & ~c_we;
      h_rvalid_r <= h_gnt_s & ~h_we;
      if (cnt_clr) begin
        cnt_r <= 16'd0;
      end else if (denied_s) begin
        cnt_r <= sat_inc16(cnt_r);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign c_gnt      = c_gnt_s;
  assign h_gnt      = h_gnt_s;
  assign m_en       = c_gnt_s | h_gnt_s;
  assign m_we       = m_we_s;
  assign m_addr     = m_addr_s;
  assign m_wdata    = m_wdata_s;
  assign c_rvalid   = c_rvalid_r;
  assign h_rvalid   = h_rvalid_r;
  assign c_rdata    = m_rdata;
  assign h_rdata    = m_rdata;
  assign core_hold  = core_hold_r;
  assign cnt_denied = cnt_r;

endmodule

// File: tb/tb_j1_mem_arbiter.sv
// Directed bench for j1_mem_arbiter with a RAM model and per-port read-data
// scoreboards; a second instance exercises the boot-hold reset behaviour.
module tb_j1_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        c_req, c_we, h_req, h_we, h_lock, cnt_clr;
  logic [15:0] c_addr, c_wdata, h_addr, h_wdata;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid, core_hold, m_en, m_we;
  logic [15:0] c_rdata, h_rdata, m_addr, m_wdata, m_rdata, cnt_denied;

  logic        c_req_b, h_lock_b;
  logic        c_gnt_b, c_rvalid_b, h_gnt_b, h_rvalid_b, core_hold_b, m_en_b, m_we_b;
  logic [15:0] c_rdata_b, h_rdata_b, m_addr_b, m_wdata_b, cnt_denied_b;

  logic [15:0] mem [0:255];
  logic [15:0] exp_c[$];
  logic [15:0] exp_h[$];
  int          checks;
  int          errors;

  j1_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BOOT_HOLD(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .h_lock(h_lock), .core_hold(core_hold),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .cnt_clr(cnt_clr), .cnt_denied(cnt_denied)
  );

  j1_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BOOT_HOLD(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req_b), .c_we(1'b1), .c_addr(16'h0000), .c_wdata(16'h0000),
    .c_gnt(c_gnt_b), .c_rvalid(c_rvalid_b), .c_rdata(c_rdata_b),
    .h_req(1'b0), .h_we(1'b0), .h_addr(16'h0000), .h_wdata(16'h0000),
    .h_gnt(h_gnt_b), .h_rvalid(h_rvalid_b), .h_rdata(h_rdata_b),
    .h_lock(h_lock_b), .core_hold(core_hold_b),
    .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_rdata(16'h0000),
    .cnt_clr(1'b0), .cnt_denied(cnt_denied_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM, one-cycle read latency, preloaded while reset is held.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'h1111;
      mem[8'h21] <= 16'h2222;
    end else if (m_en) begin
      if (m_we) mem[m_addr[7:0]] <= m_wdata;
      else m_rdata <= mem[m_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops the expected read data whenever a port presents rvalid.
  always @(negedge clk) begin
    if (c_rvalid && h_rvalid) chk("both_rvalid", 32'd1, 32'd0);
    if (c_rvalid) begin
      if (exp_c.size() == 0) chk("c_rvalid_unexpected", 32'd1, 32'd0);
      else chk("c_rdata", {16'h0, c_rdata}, {16'h0, exp_c.pop_front()});
    end
    if (h_rvalid) begin
      if (exp_h.size() == 0) chk("h_rvalid_unexpected", 32'd1, 32'd0);
      else chk("h_rdata", {16'h0, h_rdata}, {16'h0, exp_h.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; cnt_clr = 1'b0; h_lock = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0; c_wdata = 16'h0;
    h_req = 1'b0; h_we = 1'b0; h_addr = 16'h0; h_wdata = 16'h0;
    c_req_b = 1'b0; h_lock_b = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_c_gnt", {31'd0, c_gnt}, 32'd0);
    chk("rst_m_en", {31'd0, m_en}, 32'd0);
    chk("rst_core_hold", {31'd0, core_hold}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_denied}, 32'd0);
    chk("rst_core_hold_b", {31'd0, core_hold_b}, 32'd1);
    step();
    reset_n = 1'b1;

    // Continuous contention: C,H,C,H,C,H
    c_req = 1'b1; c_addr = 16'h0020; h_req = 1'b1; h_addr = 16'h0021;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_c_gnt", {31'd0, c_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_h_gnt", {31'd0, h_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) exp_c.push_back(16'h1111);
      else exp_h.push_back(16'h2222);
      step();
    end
    c_req = 1'b0; h_req = 1'b0;
    @(negedge clk);
    chk("rr_cnt", {16'd0, cnt_denied}, 32'd6);
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", {16'd0, cnt_denied}, 32'd0);

    // Lone core read of 0x0010
    step();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    @(negedge clk);
    chk("rd_c_gnt", {31'd0, c_gnt}, 32'd1);
    chk("rd_m_addr", {16'd0, m_addr}, 32'h0010);
    exp_c.push_back(16'hBEEF);
    step();
    c_req = 1'b0;
    @(negedge clk);
    chk("rd_c_rvalid", {31'd0, c_rvalid}, 32'd1);
    chk("rd_h_rvalid", {31'd0, h_rvalid}, 32'd0);

    // Core write then back-to-back read-back
    step();
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0030; c_wdata = 16'hA5A5;
    @(negedge clk);
    chk("wr_m_we", {31'd0, m_we}, 32'd1);
    chk("wr_m_wdata", {16'd0, m_wdata}, 32'h0000A5A5);
    step();
    c_we = 1'b0;
    @(negedge clk);
    chk("wr_rd_gnt", {31'd0, c_gnt}, 32'd1);
    exp_c.push_back(16'hA5A5);
    step();
    c_req = 1'b0;

    // Host lock during core traffic
    c_req = 1'b1; c_addr = 16'h0010;
    @(negedge clk);
    chk("lk_a_c_gnt", {31'd0, c_gnt}, 32'd1);
    exp_c.push_back(16'hBEEF);
    step();
    h_lock = 1'b1; h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0000; h_wdata = 16'h1000;
    @(negedge clk);
    chk("lk_b_c_gnt", {31'd0, c_gnt}, 32'd0);
    chk("lk_b_h_gnt", {31'd0, h_gnt}, 32'd1);
    step();
    for (int k = 1; k < 4; k++) begin
      h_addr = 16'(k); h_wdata = 16'h1000 + 16'(k);
      @(negedge clk);
      chk("lk_c_gnt", {31'd0, c_gnt}, 32'd0);
      chk("lk_h_gnt", {31'd0, h_gnt}, 32'd1);
      chk("lk_core_hold", {31'd0, core_hold}, (k == 1) ? 32'd0 : 32'd1);
      step();
    end
    h_lock = 1'b0; h_we = 1'b0; h_addr = 16'h0003;
    @(negedge clk);
    chk("lk_exit_h_gnt", {31'd0, h_gnt}, 32'd1);
    chk("lk_exit_c_gnt", {31'd0, c_gnt}, 32'd0);
    exp_h.push_back(16'h1003);
    step();
    @(negedge clk);
    chk("rel_m_en", {31'd0, m_en}, 32'd0);
    chk("rel_core_hold", {31'd0, core_hold}, 32'd1);
    step();
    h_addr = 16'h0002;
    @(negedge clk);
    chk("post_c_first", {31'd0, c_gnt}, 32'd1);
    chk("post_h_wait", {31'd0, h_gnt}, 32'd0);
    exp_c.push_back(16'hBEEF);
    step();
    c_req = 1'b0;
    @(negedge clk);
    chk("post_h_gnt", {31'd0, h_gnt}, 32'd1);
    chk("post_core_hold", {31'd0, core_hold}, 32'd0);
    exp_h.push_back(16'h1002);
    step();
    h_req = 1'b0;

    // Counter saturation
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; c_req = 1'b1; h_lock = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    @(negedge clk);
    chk("sat_cnt", {16'd0, cnt_denied}, 32'h0000FFFF);
    step();
    step();
    @(negedge clk);
    chk("sat_hold", {16'd0, cnt_denied}, 32'h0000FFFF);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("sat_clr", {16'd0, cnt_denied}, 32'd0);
    step();
    @(negedge clk);
    chk("sat_reinc", {16'd0, cnt_denied}, 32'd1);
    h_lock = 1'b0; c_req = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Boot hold instance: held since reset until a lock pulse
    @(negedge clk);
    chk("boot_hold_long", {31'd0, core_hold_b}, 32'd1);
    step();
    h_lock_b = 1'b1;
    step();
    h_lock_b = 1'b0; c_req_b = 1'b1;
    @(negedge clk);
    chk("boot_q_c_gnt", {31'd0, c_gnt_b}, 32'd0);
    step();
    @(negedge clk);
    chk("boot_rel_c_gnt", {31'd0, c_gnt_b}, 32'd0);
    step();
    @(negedge clk);
    chk("boot_run_c_gnt", {31'd0, c_gnt_b}, 32'd1);
    chk("boot_run_hold", {31'd0, core_hold_b}, 32'd1);
    step();
    c_req_b = 1'b0;
    @(negedge clk);
    chk("boot_hold_off", {31'd0, core_hold_b}, 32'd0);

    // Reset right after a core read grant
    step();
    c_req = 1'b1; c_addr = 16'h0010;
    @(negedge clk);
    chk("mid_c_gnt", {31'd0, c_gnt}, 32'd1);
    step();
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_c_rvalid", {31'd0, c_rvalid}, 32'd0);
    chk("mid_c_gnt_rst", {31'd0, c_gnt}, 32'd0);
    chk("mid_m_en", {31'd0, m_en}, 32'd0);
    chk("mid_cnt", {16'd0, cnt_denied}, 32'd0);
    chk("mid_hold_b", {31'd0, core_hold_b}, 32'd1);
    step();
    c_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("sb_empty", exp_c.size() + exp_h.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
